dii_pkt_buffer: RTL and testbench
=================================

DII_PKT_BUFFER -- requirements
Module: dii_pkt_buffer

Interface
REQ-001 Parameter BUF_SIZE, default 4, flit storage depth; SHALL be a power of two, at least 2.
REQ-002 Parameter FULLPACKET, default 1; 1 = store-and-forward (release only complete packets), 0 = cut-through.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flit_in  input  dii_flit (18)  upstream flit: valid, last, data[15:0].
REQ-006 flit_in_ready  output  1  buffer accepts flit_in this cycle.
REQ-007 flit_out  output  dii_flit (18)  downstream flit: valid, last, data[15:0].
REQ-008 flit_out_ready  input  1  downstream accepts flit_out this cycle.
REQ-009 packet_count  output  $clog2(BUF_SIZE+1)  number of complete packets currently held.

Function
REQ-010 Write SHALL occur iff flit_in.valid && flit_in_ready; {last, data} stored at write pointer, write pointer increments modulo BUF_SIZE.
REQ-011 Read SHALL occur iff flit_out.valid && flit_out_ready; read pointer increments modulo BUF_SIZE.
REQ-012 Occupancy counter (0..BUF_SIZE) SHALL be +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-013 flit_in_ready SHALL be 1 iff occupancy < BUF_SIZE; when full, a same-cycle read does not raise ready (no write-through-when-full).
REQ-014 packet_count SHALL be +1 on write of a last flit, -1 on read of a last flit, unchanged when both occur in the same cycle.
REQ-015 flit_out.data and flit_out.last SHALL reflect the entry at the read pointer; flit_out SHALL be all-zero when flit_out.valid is 0.
REQ-016 FULLPACKET=0: flit_out.valid SHALL be 1 iff occupancy > 0.
REQ-017 FULLPACKET=1: flit_out.valid SHALL be 1 iff occupancy > 0 and (packet_count > 0 or occupancy == BUF_SIZE); the full-buffer clause guarantees forward progress for packets longer than BUF_SIZE.
REQ-018 No empty bypass: a flit written in cycle N SHALL first appear on flit_out in cycle N+1 (FULLPACKET=0); with FULLPACKET=1, leading flits of a packet appear in the cycle after its last flit is written.
REQ-019 flit_out SHALL remain stable while flit_out.valid && !flit_out_ready.
REQ-020 Single-flit packets (valid and last together) SHALL be handled as complete packets.
REQ-021 Pointer wrap-around SHALL be seamless, with no bubble at the BUF_SIZE-1 to 0 transition.

Reset
REQ-022 While rst is high: pointers, occupancy and packet_count SHALL be cleared in the next edge; flit_out.valid=0, flit_out all-zero, flit_in_ready=1 after that edge.
REQ-023 Reset mid-packet SHALL discard all stored flits; storage contents need not be cleared.
REQ-024 Flits presented during the cycle rst is high SHALL NOT be stored.

Structure
REQ-025 dii_flit typedef SHALL come from dii_package; no new package types are needed.
REQ-026 Pointer width $clog2(BUF_SIZE); occupancy and packet_count width $clog2(BUF_SIZE+1).
REQ-027 No sub-module; storage SHALL be an inferred register array of BUF_SIZE x 17 bits.

Verification
REQ-028 FULLPACKET=1: write 3-flit packet 0x0001,0x0002,0x0003(last), flit_out_ready=1 -> flit_out.valid stays 0 until the cycle after 0x0003 is written, then 0x0001..0x0003 on consecutive cycles, last on the third; packet_count 1->0.
REQ-029 FULLPACKET=1, BUF_SIZE=4: 6-flit packet with flit_out_ready=1 -> flit_in_ready drops after 4 writes, output releases while full, all 6 flits delivered in order, last only on the 6th.
REQ-030 FULLPACKET=0, flit_out_ready=0: write 4 flits -> flit_in_ready=0, occupancy 4; raise ready -> drain in order, flit_in_ready returns to 1 the cycle after the first read.
REQ-031 Simultaneous write of last flit and read of last flit with packet_count=1 -> packet_count stays 1.
REQ-032 Back-to-back single-flit packets 0xA5A5, 0x5A5A over 10 writes spanning 2+ pointer wraps -> output order and data match, no bubbles once streaming.
REQ-033 Assert rst after 2 flits of a 4-flit packet -> next cycle flit_out.valid=0, packet_count=0, flit_in_ready=1; a fresh packet then passes normally.

Source files
------------

// File: rtl/dii_package.sv
// Shared types for the DII flit interface.
package dii_package;

    localparam int DII_DATA_W = 16;

    // One flit on the wire: handshake valid, end-of-packet marker, payload.
    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [DII_DATA_W-1:0] data;
    } dii_flit;

endpackage

// File: rtl/dii_pkt_buffer.sv
// Flit FIFO between two DII ports. With FULLPACKET=1 the output is held back
// until a complete packet is stored (or the buffer is full, so packets longer
// than the buffer still make progress); with FULLPACKET=0 it is cut-through.
// BUF_SIZE must be a power of two (>= 2) so the pointers wrap naturally.
// There is no empty bypass: a flit is visible on the output one cycle after
// it is written. All outputs are decoded from flops only.
module dii_pkt_buffer
    import dii_package::*;
#(
    parameter int BUF_SIZE   = 4,
    parameter int FULLPACKET = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  dii_flit                         flit_in,
    output logic                            flit_in_ready,
    output dii_flit                         flit_out,
    input  logic                            flit_out_ready,
    output logic [$clog2(BUF_SIZE+1)-1:0]   packet_count
);

    localparam int PTR_W = $clog2(BUF_SIZE);
    localparam int CNT_W = $clog2(BUF_SIZE + 1);
    localparam int ENT_W = DII_DATA_W + 1;

    localparam logic [CNT_W-1:0] FULL_OCC = CNT_W'(BUF_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Storage: {last, data} per entry, never reset (contents behind the
    // pointers are simply ignored after a reset).
    logic [ENT_W-1:0] mem_q [BUF_SIZE];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q,    occ_d;
    logic [CNT_W-1:0] pkt_q,    pkt_d;

    logic             full_s;
    logic             empty_s;
    logic             out_valid_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic [ENT_W-1:0] head_s;
    logic [ENT_W-1:0] wr_data_s;

    // Status decode and output-release rule from the registered state.
    always_comb begin
        full_s  = (occ_q == FULL_OCC);
        empty_s = (occ_q == CNT_ZERO);
        if (empty_s) begin
            out_valid_s = 1'b0;
        end else if (FULLPACKET != 0) begin
            // Release only whole packets, unless the buffer is jammed full
            // with part of a packet that will never fit.
            out_valid_s = (pkt_q != CNT_ZERO) || full_s;
        end else begin
            out_valid_s = 1'b1;
        end
    end

    // Handshakes: ready depends only on stored occupancy, so a read in the
    // same cycle does not open a slot for a write while full.
    always_comb begin
        flit_in_ready = !full_s;
        wr_en_s       = flit_in.valid && !full_s;
        rd_en_s       = out_valid_s && flit_out_ready;
        wr_data_s     = {flit_in.last, flit_in.data};
        head_s        = mem_q[rd_ptr_q];
    end

    // Output flit: head entry when valid, all-zero otherwise.
    always_comb begin
        if (out_valid_s) begin
            flit_out = {1'b1, head_s};
        end else begin
            flit_out = '0;
        end
        packet_count = pkt_q;
    end

    // Next-state for pointers, occupancy and complete-packet count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        pkt_d    = pkt_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   occ_d = occ_q + CNT_ONE;
            2'b01:   occ_d = occ_q - CNT_ONE;
            default: occ_d = occ_q;
        endcase

        // A packet completes when its last flit is written and leaves when
        // its last flit is read; both together cancel out.
        case ({wr_en_s && flit_in.last, rd_en_s && head_s[ENT_W-1]})
            2'b10:   pkt_d = pkt_q + CNT_ONE;
            2'b01:   pkt_d = pkt_q - CNT_ONE;
            default: pkt_d = pkt_q;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            pkt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            pkt_q    <= pkt_d;
        end
    end

    // Storage write; flits offered while reset is high are dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

endmodule

// File: tb/tb_dii_pkt_buffer.sv
// Bench for dii_pkt_buffer: one store-and-forward and one cut-through
// instance, a queue-based reference model checked every cycle, and directed
// scenarios with literal expectations.
module tb_dii_pkt_buffer;
    import dii_package::*;

    localparam int BUF = 4;

    logic        clk;
    logic        rst;
    dii_flit     fin   [2];
    dii_flit     fout  [2];
    logic        frdy  [2];
    logic        ordy  [2];
    logic [2:0]  pc    [2];

    int checks;
    int errors;
    logic chk_en;

    // Reference model: stored flits as {last, data}, oldest first.
    logic [16:0] mq [2][$];

    dii_pkt_buffer #(.BUF_SIZE(BUF), .FULLPACKET(1)) u_dut_sf (
        .clk(clk), .rst(rst), .flit_in(fin[0]), .flit_in_ready(frdy[0]),
        .flit_out(fout[0]), .flit_out_ready(ordy[0]), .packet_count(pc[0])
    );

    dii_pkt_buffer #(.BUF_SIZE(BUF), .FULLPACKET(0)) u_dut_ct (
        .clk(clk), .rst(rst), .flit_in(fin[1]), .flit_in_ready(frdy[1]),
        .flit_out(fout[1]), .flit_out_ready(ordy[1]), .packet_count(pc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int m_pkts(input int i);
        int n = 0;
        for (int k = 0; k < mq[i].size(); k++) begin
            if (mq[i][k][16]) n++;
        end
        return n;
    endfunction

    function automatic logic m_valid(input int i);
        int sz = mq[i].size();
        if (sz == 0) return 1'b0;
        if (i == 1) return 1'b1;
        return (m_pkts(i) > 0) || (sz == BUF);
    endfunction

    function automatic logic [17:0] m_out(input int i);
        if (m_valid(i)) return {1'b1, mq[i][0]};
        return 18'd0;
    endfunction

    function automatic logic m_ready(input int i);
        return mq[i].size() < BUF;
    endfunction

    task automatic model_step();
        logic wr;
        logic rd;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
            end else begin
                wr = fin[i].valid && m_ready(i);
                rd = m_valid(i) && ordy[i];
                if (rd) void'(mq[i].pop_front());
                if (wr) mq[i].push_back({fin[i].last, fin[i].data});
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("mdl_ready%0d", i), {31'd0, frdy[i]}, {31'd0, m_ready(i)});
                check($sformatf("mdl_out%0d", i), {14'd0, fout[i]}, {14'd0, m_out(i)});
                check($sformatf("mdl_pcnt%0d", i), {29'd0, pc[i]}, m_pkts(i));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic l, input logic [15:0] d);
        fin[i] = {v, l, d};
    endtask

    task automatic exp_out(input string name, input int i, input logic v, input logic l, input logic [15:0] d);
        check(name, {14'd0, fout[i]}, {14'd0, v, l, d});
    endtask

    task automatic exp_rp(input string name, input int i, input logic r, input logic [2:0] p);
        check({name, "_rdy"}, {31'd0, frdy[i]}, {31'd0, r});
        check({name, "_pc"}, {29'd0, pc[i]}, {29'd0, p});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] pat;
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fin[i]  = '0;
            ordy[i] = 1'b0;
        end
        // A flit offered during reset must not be kept.
        drive(0, 1'b1, 1'b1, 16'hDEAD);
        step();
        step();
        drive(0, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_out($sformatf("reset_out%0d", i), i, 1'b0, 1'b0, 16'h0000);
            exp_rp($sformatf("reset%0d", i), i, 1'b1, 3'd0);
        end
        step();
        exp_out("rst_drop_out", 0, 1'b0, 1'b0, 16'h0000);

        // Store-and-forward of a 3-flit packet.
        ordy[0] = 1'b1;
        drive(0, 1'b1, 1'b0, 16'h0001);
        step();
        exp_out("sf3_hold1", 0, 1'b0, 1'b0, 16'h0000);
        drive(0, 1'b1, 1'b0, 16'h0002);
        step();
        exp_out("sf3_hold2", 0, 1'b0, 1'b0, 16'h0000);
        drive(0, 1'b1, 1'b1, 16'h0003);
        step();
        drive(0, 1'b0, 1'b0, 16'h0000);
        exp_out("sf3_f1", 0, 1'b1, 1'b0, 16'h0001);
        exp_rp("sf3_f1", 0, 1'b1, 3'd1);
        step();
        exp_out("sf3_f2", 0, 1'b1, 1'b0, 16'h0002);
        step();
        exp_out("sf3_f3", 0, 1'b1, 1'b1, 16'h0003);
        exp_rp("sf3_f3", 0, 1'b1, 3'd1);
        step();
        exp_out("sf3_done", 0, 1'b0, 1'b0, 16'h0000);
        exp_rp("sf3_done", 0, 1'b1, 3'd0);

        // Simultaneous write-last and read-last keeps packet_count at 1.
        ordy[0] = 1'b0;
        drive(0, 1'b1, 1'b1, 16'h0011);
        step();
        exp_out("sim_pre", 0, 1'b1, 1'b1, 16'h0011);
        exp_rp("sim_pre", 0, 1'b1, 3'd1);
        ordy[0] = 1'b1;
        drive(0, 1'b1, 1'b1, 16'h0022);
        step();
        drive(0, 1'b0, 1'b0, 16'h0000);
        exp_rp("sim_both", 0, 1'b1, 3'd1);
        exp_out("sim_both", 0, 1'b1, 1'b1, 16'h0022);
        step();
        exp_rp("sim_drain", 0, 1'b1, 3'd0);

        // 6-flit packet through a 4-deep store-and-forward buffer.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 1'b0, 16'h0100 + 16'(k));
            step();
        end
        drive(0, 1'b1, 1'b0, 16'h0104);
        exp_rp("long_full", 0, 1'b0, 3'd0);
        exp_out("long_o0", 0, 1'b1, 1'b0, 16'h0100);
        step();
        exp_rp("long_slot", 0, 1'b1, 3'd0);
        exp_out("long_gap", 0, 1'b0, 1'b0, 16'h0000);
        step();
        exp_out("long_o1", 0, 1'b1, 1'b0, 16'h0101);
        drive(0, 1'b1, 1'b1, 16'h0105);
        step();
        exp_out("long_gap2", 0, 1'b0, 1'b0, 16'h0000);
        step();
        drive(0, 1'b0, 1'b0, 16'h0000);
        exp_rp("long_last_in", 0, 1'b0, 3'd1);
        for (int k = 2; k < 6; k++) begin
            exp_out($sformatf("long_o%0d", k), 0, 1'b1, (k == 5), 16'h0100 + 16'(k));
            step();
        end
        exp_out("long_done", 0, 1'b0, 1'b0, 16'h0000);
        exp_rp("long_done", 0, 1'b1, 3'd0);

        // Cut-through: fill with output stalled, then drain.
        ordy[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1'b1, (k == 3), 16'h0401 + 16'(k));
            step();
            if (k == 0) exp_out("ct_latency", 1, 1'b1, 1'b0, 16'h0401);
        end
        drive(1, 1'b0, 1'b0, 16'h0000);
        exp_rp("ct_full", 1, 1'b0, 3'd1);
        exp_out("ct_full", 1, 1'b1, 1'b0, 16'h0401);
        step();
        exp_out("ct_stall", 1, 1'b1, 1'b0, 16'h0401);
        ordy[1] = 1'b1;
        step();
        exp_rp("ct_d1", 1, 1'b1, 3'd1);
        exp_out("ct_d1", 1, 1'b1, 1'b0, 16'h0402);
        step();
        exp_out("ct_d2", 1, 1'b1, 1'b0, 16'h0403);
        step();
        exp_out("ct_d3", 1, 1'b1, 1'b1, 16'h0404);
        step();
        exp_out("ct_empty", 1, 1'b0, 1'b0, 16'h0000);
        exp_rp("ct_empty", 1, 1'b1, 3'd0);

        // Back-to-back single-flit packets across several pointer wraps.
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pat = (k % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
            drive(0, 1'b1, 1'b1, pat);
            drive(1, 1'b1, 1'b1, pat);
            step();
            for (int i = 0; i < 2; i++) begin
                exp_out($sformatf("stream%0d_k%0d", i, k), i, 1'b1, 1'b1, pat);
                exp_rp($sformatf("stream%0d_k%0d", i, k), i, 1'b1, 3'd1);
            end
        end
        drive(0, 1'b0, 1'b0, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000);
        step();
        exp_out("stream_end0", 0, 1'b0, 1'b0, 16'h0000);
        exp_out("stream_end1", 1, 1'b0, 1'b0, 16'h0000);

        // Reset in the middle of a packet, then a fresh packet.
        ordy[0] = 1'b0;
        drive(0, 1'b1, 1'b0, 16'h0201);
        step();
        drive(0, 1'b1, 1'b0, 16'h0202);
        step();
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 16'h0203);
        step();
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0000);
        exp_out("mrst_out", 0, 1'b0, 1'b0, 16'h0000);
        exp_rp("mrst", 0, 1'b1, 3'd0);
        ordy[0] = 1'b1;
        drive(0, 1'b1, 1'b0, 16'h0301);
        step();
        drive(0, 1'b1, 1'b1, 16'h0302);
        step();
        drive(0, 1'b0, 1'b0, 16'h0000);
        exp_out("fresh_f1", 0, 1'b1, 1'b0, 16'h0301);
        exp_rp("fresh_f1", 0, 1'b1, 3'd1);
        step();
        exp_out("fresh_f2", 0, 1'b1, 1'b1, 16'h0302);
        step();
        exp_out("fresh_done", 0, 1'b0, 1'b0, 16'h0000);
        exp_rp("fresh_done", 0, 1'b1, 3'd0);

        step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
